// File: rtl/vs_fp_dot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vs_fp_dot_seq_pkg
// Description : Shared fixed-point types, saturation bounds and dot-sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vs_fp_dot_seq_pkg;

    typedef logic signed [31:0] fp_32_t;
    typedef logic signed [63:0] fp_64_t;

    // Symmetric bounds, matching the saturated adder.
    localparam fp_32_t FP_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP_MIN = -32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vs_dot_state_t;

endpackage
`default_nettype wire

// File: rtl/vs_fp_shift_sat.sv
`default_nettype none
// ============================================================================
// Module      : vs_fp_shift_sat
// Description : Arithmetic right shift by Q, then symmetric saturation of a
//               64-bit value to fp_32_t with a clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vs_fp_shift_sat
    import vs_fp_dot_seq_pkg::*;
#(
    parameter int Q = 15
) (
    input  fp_64_t i_value,
    output fp_32_t o_value,
    output logic   o_clip
);

    fp_64_t w_shifted;
    logic   w_above;
    logic   w_below;

    always_comb begin
        w_shifted = i_value >>> Q;
        w_above   = w_shifted > fp_64_t'(FP_MAX);
        w_below   = w_shifted < fp_64_t'(FP_MIN);
        o_clip    = w_above | w_below;
        if (w_above) begin
            o_value = FP_MAX;
        end else if (w_below) begin
            o_value = FP_MIN;
        end else begin
            o_value = w_shifted[31:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vs_fp_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : vs_fp_dot_seq
// Description : Job-controlled Q-format dot product: streams operand pairs,
//               accumulates in 64 bits, emits a scaled, saturated result.
// Revision    : 1.0 - initial release
// ============================================================================
module vs_fp_dot_seq
    import vs_fp_dot_seq_pkg::*;
#(
    parameter int Q     = 15,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_32_t           a_in,
    input  fp_32_t           b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output fp_32_t           result,
    output logic             overflow
);

    vs_dot_state_t    r_state;
    vs_dot_state_t    w_state_next;
    fp_64_t           r_acc;
    fp_64_t           r_prod;
    logic             r_prod_v;
    logic [LEN_W-1:0] r_remaining;

    fp_64_t w_prod;
    fp_64_t w_acc_next;
    fp_32_t w_sat;
    logic   w_clip;
    logic   w_fire;

    assign w_fire     = in_valid && in_ready;
    assign w_prod     = fp_64_t'(a_in) * fp_64_t'(b_in);
    // A pending product is folded in whenever present, so stalls never lose it.
    assign w_acc_next = r_prod_v ? (r_acc + r_prod) : r_acc;

    vs_fp_shift_sat #(
        .Q (Q)
    ) u_shift_sat (
        .i_value (w_acc_next),
        .o_value (w_sat),
        .o_clip  (w_clip)
    );

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        in_ready     = (r_state == ST_ACCUM);
        out_valid    = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (len == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM: if (w_fire && (r_remaining == LEN_W'(1))) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_remaining <= '0;
            result      <= '0;
            overflow    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_prod_v    <= 1'b0;
                        r_remaining <= len;
                        if (len == '0) begin
                            result   <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                ST_ACCUM: begin
                    r_acc    <= w_acc_next;
                    r_prod_v <= w_fire;
                    if (w_fire) begin
                        r_prod      <= w_prod;
                        r_remaining <= r_remaining - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_acc    <= w_acc_next;
                    r_prod_v <= 1'b0;
                    result   <= w_sat;
                    overflow <= w_clip;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
